// File: rtl/seq_mult.sv
// Shift-add multiplier, BITS_PER_CYCLE multiplier bits per cycle; WIDTH/BITS_PER_CYCLE cycles accept->out_valid.
// Backpressure: result held in DONE until out_ready; new operands accepted only in IDLE.
module seq_mult #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_param
            $error("seq_mult: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     product_q, product_d;
    logic [PW-1:0]     step_sum;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    always_comb begin
        step_sum = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                step_sum = step_sum + (mcand_q << k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Negating a zero magnitude yields zero, so no negative-zero case.
                    product_d = neg_q ? (~step_sum + PW'(1)) : step_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: 64-bit BITS_PER_CYCLE=1 instance plus 8-bit instances at 1, 2 and 4 bits per cycle.
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 64-bit instance
    logic          iv, ir, sm, ov, ordy;
    logic [63:0]   a64, b64;
    logic [127:0]  p64;

    seq_mult #(.WIDTH(64), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .a(a64), .b(b64), .signed_mode(sm),
        .out_valid(ov), .out_ready(ordy), .product(p64)
    );

    // 8-bit instances, BITS_PER_CYCLE = 1, 2, 4
    logic        iv8[3], ir8[3], sm8[3], ov8[3], or8[3];
    logic [7:0]  a8[3], b8[3];
    logic [15:0] p8[3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_sweep
            seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u_dut8 (
                .clk(clk), .rst_n(rst_n),
                .in_valid(iv8[g]), .in_ready(ir8[g]),
                .a(a8[g]), .b(b8[g]), .signed_mode(sm8[g]),
                .out_valid(ov8[g]), .out_ready(or8[g]), .product(p8[g])
            );
        end
    endgenerate

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ex, ey, pr;
        ex = s ? int'($signed(x)) : int'(x);
        ey = s ? int'($signed(y)) : int'(y);
        pr = ex * ey;
        return pr[15:0];
    endfunction

    task automatic start64(input string tag, input logic [63:0] ta, input logic [63:0] tb_v, input logic tsm);
        @(negedge clk);
        check_eq({tag, "_accept_rdy"}, ir, 1'b1);
        a64 = ta; b64 = tb_v; sm = tsm; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
    endtask

    // Called at the first negedge after the accept edge; lat counts edges until out_valid.
    task automatic wait64(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!ov && lat < 300) begin
            if (ir) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop64(input string tag);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check_eq({tag, "_ov_drop"}, ov, 1'b0);
    endtask

    task automatic op64(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tsm, input logic [127:0] exp);
        int lat;
        bit rdy_seen;
        start64(tag, ta, tb_v, tsm);
        wait64(lat, rdy_seen);
        check_eq({tag, "_lat"}, lat, 64);
        check_eq({tag, "_rdy_low"}, rdy_seen, 1'b0);
        check_eq({tag, "_prod"}, p64, exp);
        pop64(tag);
    endtask

    // Entered and left at a negedge, so consecutive calls give back-to-back traffic.
    task automatic op8(input int idx, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tsm, input int stall);
        int lat, wt;
        logic [15:0] exp;
        exp = ref8(ta, tb_v, tsm);
        a8[idx] = ta; b8[idx] = tb_v; sm8[idx] = tsm; iv8[idx] = 1'b1;
        wt = 0;
        while (!ir8[idx] && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check_eq($sformatf("s%0d_rdy", idx), ir8[idx], 1'b1);
        @(negedge clk);
        iv8[idx] = 1'b0;
        lat = 0;
        while (!ov8[idx] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("s%0d_lat a=%0h b=%0h", idx, ta, tb_v), lat, 8 >> idx);
        check_eq($sformatf("s%0d_prod a=%0h b=%0h s=%0d", idx, ta, tb_v, tsm), p8[idx], exp);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_eq($sformatf("s%0d_stall_prod", idx), p8[idx], exp);
            check_eq($sformatf("s%0d_stall_ov", idx), ov8[idx], 1'b1);
        end
        or8[idx] = 1'b1;
        @(negedge clk);
        or8[idx] = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses;
        bit rdy_seen, stable;
        logic [7:0] ca[6];
        logic [7:0] cb[6];

        ca = '{8'h00, 8'h80, 8'hFF, 8'h80, 8'h01, 8'h7F};
        cb = '{8'hF9, 8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h7F};

        rst_n = 1'b0;
        iv = 1'b0; sm = 1'b0; ordy = 1'b0; a64 = '0; b64 = '0;
        for (int i = 0; i < 3; i++) begin
            iv8[i] = 1'b0; sm8[i] = 1'b0; or8[i] = 1'b0; a8[i] = '0; b8[i] = '0;
        end

        #12;
        check_eq("rst_in_ready", ir, 1'b1);
        check_eq("rst_out_valid", ov, 1'b0);
        check_eq("rst_product", p64, 128'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("s%0d_rst_product", i), p8[i], 16'd0);
            check_eq($sformatf("s%0d_rst_out_valid", i), ov8[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        op64("u_3x5", 64'd3, 64'd5, 1'b0, 128'd15);
        op64("s_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        op64("s_min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
             128'h4000_0000_0000_0000_0000_0000_0000_0000);
        op64("u_min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
             128'h4000_0000_0000_0000_0000_0000_0000_0000);
        op64("s_0xm7", 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 128'd0);
        op64("u_max_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        op64("s_m1xm1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1);
        op64("s_7xm1", 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9);

        // Backpressure: result held while new operands are offered
        start64("bp", 64'd7, 64'd9, 1'b0);
        wait64(lat, rdy_seen);
        check_eq("bp_lat", lat, 64);
        check_eq("bp_prod", p64, 128'd63);
        a64 = 64'd11; b64 = 64'd13; sm = 1'b0; iv = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p64 !== 128'd63 || ov !== 1'b1 || ir !== 1'b0) stable = 1'b0;
        end
        check_eq("bp_hold_stable", stable, 1'b1);
        check_eq("bp_hold_prod", p64, 128'd63);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check_eq("bp_idle_ov", ov, 1'b0);
        check_eq("bp_idle_rdy", ir, 1'b1);
        @(negedge clk);
        iv = 1'b0;
        check_eq("bp_accept_rdy", ir, 1'b0);
        wait64(lat, rdy_seen);
        check_eq("bp2_lat", lat, 64);
        check_eq("bp2_prod", p64, 128'd143);
        pop64("bp2");

        // Asynchronous reset in the middle of CALC
        start64("rst", 64'd100, 64'd200, 1'b0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ov", ov, 1'b0);
        check_eq("rst_mid_prod", p64, 128'd0);
        check_eq("rst_mid_rdy", ir, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov) pulses++;
        end
        check_eq("rst_no_pulse", pulses, 0);
        op64("post_rst", 64'd100, 64'd200, 1'b0, 128'd20000);

        // Narrow instances: corners in both modes, then random back-to-back with stalls
        for (int idx = 0; idx < 3; idx++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 6; c++) begin
                    op8(idx, ca[c], cb[c], m[0], 0);
                end
            end
            for (int r = 0; r < 400; r++) begin
                op8(idx, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
